// File: rtl/apb_initiator.sv
// APB4 initiator: turns a single-outstanding valid/ready request into one APB4
// transfer and returns read data and error status on a valid/ready response.

package apb_initiator_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
endpackage

// state  | meaning
// IDLE   | ready for a request, APB bus idle
// SETUP  | psel=1, penable=0, wait counter cleared
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | bus idle, response presented until rsp_ready_i
module apb_initiator #(
    parameter int unsigned ApbAddrWidth  = 32,
    parameter int unsigned ApbDataWidth  = 32,
    parameter int unsigned TimeoutCycles = 0,
    parameter type         req_t         = apb_initiator_pkg::apb_req_t,
    parameter type         resp_t        = apb_initiator_pkg::apb_resp_t
) (
    input  logic                            pclk_i,
    input  logic                            preset_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ApbAddrWidth-1:0]         req_addr_i,
    input  logic                            req_write_i,
    input  logic [ApbDataWidth-1:0]         req_wdata_i,
    input  logic [(ApbDataWidth+7)/8-1:0]   req_strb_i,
    input  logic [2:0]                      req_prot_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [ApbDataWidth-1:0]         rsp_rdata_o,
    output logic [1:0]                      rsp_err_o,
    output req_t                            req_o,
    input  resp_t                           resp_i
);

    localparam int unsigned StrbWidth = (ApbDataWidth + 7) / 8;
    localparam int unsigned CntWidth  = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ApbAddrWidth-1:0] addr_q;
    logic                    write_q;
    logic [ApbDataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0]    strb_q;
    logic [2:0]              prot_q;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [ApbDataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]              err_q, err_d;
    logic                    load;
    logic                    timeout_hit;

    // Counter value after this wait cycle, widened so the compare never wraps.
    assign timeout_hit = (TimeoutCycles != 0) &&
                         ((32'(cnt_q) + 32'd1) >= TimeoutCycles);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (resp_i.pready) begin
                    rdata_d = write_q ? '0 : resp_i.prdata[ApbDataWidth-1:0];
                    err_d   = {1'b0, resp_i.pslverr};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (timeout_hit) begin
                        rdata_d = '0;
                        err_d   = 2'b10;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (load) begin
                addr_q  <= req_addr_i;
                write_q <= req_write_i;
                wdata_q <= req_wdata_i;
                strb_q  <= req_write_i ? req_strb_i : '0;
                prot_q  <= req_prot_i;
            end
        end
    end

    // psel/penable are decoded from state so reset drops them without a clock edge.
    always_comb begin
        req_o         = '0;
        req_o.paddr   = addr_q;
        req_o.pprot   = prot_q;
        req_o.psel    = (state_q == SETUP) || (state_q == ACCESS);
        req_o.penable = (state_q == ACCESS);
        req_o.pwrite  = write_q;
        req_o.pwdata  = wdata_q;
        req_o.pstrb   = strb_q;
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator with a queue-based response scoreboard.
module tb_apb_initiator;
    import apb_initiator_pkg::*;

    localparam int T = 4;

    logic        pclk_i = 1'b0;
    logic        preset_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    apb_req_t    req_o;
    apb_resp_t   resp_i;

    apb_initiator #(
        .ApbAddrWidth (32),
        .ApbDataWidth (32),
        .TimeoutCycles(T)
    ) dut (
        .pclk_i     (pclk_i),
        .preset_ni  (preset_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i),
        .req_strb_i (req_strb_i),
        .req_prot_i (req_prot_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .req_o      (req_o),
        .resp_i     (resp_i)
    );

    always #5 pclk_i = ~pclk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge pclk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: pready after wait_n wait states in ACCESS
    int          wait_n = 0;
    int          acc_idx = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    initial resp_i = '0;
    always @(negedge pclk_i) begin
        if (req_o.psel && req_o.penable) begin
            resp_i.pready  = (acc_idx == wait_n);
            resp_i.prdata  = slv_rdata;
            resp_i.pslverr = slv_err;
            acc_idx++;
        end else begin
            resp_i  = '0;
            acc_idx = 0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    logic seen = 1'b0;

    always @(negedge pclk_i) begin
        if (preset_ni && rsp_valid_o) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got valid with rdata %0h err %0h, required none",
                         rsp_rdata_o, rsp_err_o);
            end else begin
                check("rsp_rdata", rsp_rdata_o, sbq[0].rdata);
                check("rsp_err", rsp_err_o, sbq[0].err);
                check("rsp_req_ready_low", req_ready_o, 1'b0);
                check("rsp_psel_low", req_o.psel, 1'b0);
                if (!seen) begin
                    check("rsp_cycle", 64'(cyc), 64'(sbq[0].cyc));
                    seen = 1'b1;
                end
                if (rsp_ready_i) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called #1 after a posedge while the DUT is in IDLE.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] slave_rd, input logic slave_err,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input int exp_lat, input int hold);
        int k;
        exp_t e;
        wait_n      = waits;
        slv_rdata   = slave_rd;
        slv_err     = slave_err;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_strb_i  = strb;
        req_prot_i  = prot;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        k = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = k + exp_lat;
        sbq.push_back(e);
        @(negedge pclk_i);
        check("idle_req_ready", req_ready_o, 1'b1);
        @(posedge pclk_i);
        #1;
        req_valid_i = 1'b0;
        for (int c = 1; c < exp_lat; c++) begin
            @(negedge pclk_i);
            check("psel", req_o.psel, 1'b1);
            check("penable", req_o.penable, (c >= 2));
            check("paddr", req_o.paddr, addr);
            check("pwrite", req_o.pwrite, wr);
            check("pwdata", req_o.pwdata, wdata);
            check("pstrb", req_o.pstrb, wr ? strb : 4'b0000);
            check("pprot", req_o.pprot, prot);
            check("busy_req_ready", req_ready_o, 1'b0);
            @(posedge pclk_i);
            #1;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge pclk_i);
            #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge pclk_i);
        #1;
        @(negedge pclk_i);
        check("post_hs_idle", req_ready_o, 1'b1);
        check("post_hs_valid", rsp_valid_o, 1'b0);
        check("post_hs_pending", 64'(sbq.size()), 64'd0);
        sbq.delete();
        seen = 1'b0;
        @(posedge pclk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        preset_ni   = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        req_prot_i  = '0;
        rsp_ready_i = 1'b0;
        repeat (2) @(posedge pclk_i);
        #1;
        check("rst_psel", req_o.psel, 1'b0);
        check("rst_penable", req_o.penable, 1'b0);
        check("rst_paddr", req_o.paddr, 32'h0);
        check("rst_pwdata", req_o.pwdata, 32'h0);
        check("rst_pstrb", req_o.pstrb, 4'h0);
        check("rst_pprot", req_o.pprot, 3'h0);
        check("rst_pwrite", req_o.pwrite, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_rsp_err", rsp_err_o, 2'b00);
        check("rst_req_ready", req_ready_o, 1'b1);
        preset_ni = 1'b1;
        @(posedge pclk_i);
        #1;

        //   wr    addr        wdata         strb     prot  waits slave_rd      serr  exp_rdata     err    lat hold
        xfer(1'b0, 32'h10,     32'h0,        4'h0,    3'd0, 0,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2'b00, 3,  0);
        xfer(1'b1, 32'h24,     32'hA5A5_A5A5, 4'b0101, 3'd2, 3,    32'h1234_5678, 1'b0, 32'h0,         2'b00, 6,  0);
        xfer(1'b0, 32'h28,     32'h0,        4'b1111, 3'd1, 1,    32'h0BAD_BEEF, 1'b0, 32'h0BAD_BEEF, 2'b00, 4,  0);
        xfer(1'b0, 32'h30,     32'h0,        4'h0,    3'd0, 2,    32'hDEAD_0001, 1'b1, 32'hDEAD_0001, 2'b01, 5,  0);
        xfer(1'b0, 32'h40,     32'h0,        4'h0,    3'd7, 99,   32'hFFFF_FFFF, 1'b0, 32'h0,         2'b10, 6,  0);
        xfer(1'b0, 32'h44,     32'h0,        4'h0,    3'd3, 3,    32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 2'b00, 6,  0);
        xfer(1'b0, 32'h48,     32'h0,        4'h0,    3'd0, 0,    32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 2'b00, 3,  5);
        xfer(1'b1, 32'h4C,     32'h0F0F_0F0F, 4'b1000, 3'd5, 1,    32'h7777_7777, 1'b1, 32'h0,         2'b01, 4,  2);
        xfer(1'b1, 32'h50,     32'hFFFF_0000, 4'b1111, 3'd0, 99,   32'h0,         1'b1, 32'h0,         2'b10, 6,  0);

        // Reset during an ACCESS wait state
        wait_n      = 3;
        slv_rdata   = 32'h9999_9999;
        slv_err     = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 32'h60;
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge pclk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge pclk_i);
        #1;
        check("pre_rst_penable", req_o.penable, 1'b1);
        #2;
        preset_ni = 1'b0;
        #1;
        check("async_rst_psel", req_o.psel, 1'b0);
        check("async_rst_penable", req_o.penable, 1'b0);
        check("async_rst_rsp_valid", rsp_valid_o, 1'b0);
        check("async_rst_req_ready", req_ready_o, 1'b1);
        repeat (2) @(posedge pclk_i);
        #1;
        preset_ni = 1'b1;
        repeat (4) @(posedge pclk_i);
        #1;
        check("post_rst_no_rsp", rsp_valid_o, 1'b0);

        xfer(1'b0, 32'h64,     32'h0,        4'h0,    3'd0, 1,    32'h2468_ACE0, 1'b0, 32'h2468_ACE0, 2'b00, 4,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
